misa_ctrl: RTL

MISA_CTRL -- requirements
Module: misa_ctrl

---
 rtl/misa_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/misa_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : misa_ctrl
// Description : misa CSR holder. Legalises software writes to the extension
//               field, drains the pipeline through a flush handshake and only
//               then switches the live extension enables.
// Revision    : 1.0 - initial release
// ============================================================================
module misa_ctrl #(
  parameter int          XLEN         = 64,
  parameter int          FPU_EN       = 0,
  parameter int          C_EXT_EN     = 1,
  parameter int          A_EXT_EN     = 1,
  parameter logic [25:0] MUTABLE_MASK = 26'h0000025
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            csr_we_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic            csr_ready_o,
  input  logic [XLEN-1:0] next_pc_i,
  output logic            flush_req_o,
  input  logic            flush_ack_i,
  output logic [XLEN-1:0] misa_o,
  output logic [25:0]     ext_en_o,
  output logic            change_o
);

  // Extension bit positions used by the legalisation rules
  localparam int EXT_C = 2;
  localparam int EXT_D = 3;
  localparam int EXT_F = 5;

  // Always-present base: I(8), M(12), S(18), U(20)
  localparam logic [25:0] BASE_EXT  = 26'h0141100;
  localparam logic [25:0] A_BIT     = (A_EXT_EN != 0) ? 26'h0000001 : 26'h0;
  localparam logic [25:0] C_BIT     = (C_EXT_EN != 0) ? 26'h0000004 : 26'h0;
  localparam logic [25:0] F_BIT     = (FPU_EN != 0)   ? 26'h0000020 : 26'h0;
  localparam logic [25:0] D_BIT     = ((FPU_EN != 0) && (XLEN == 64)) ? 26'h0000008 : 26'h0;
  localparam logic [25:0] SUPPORTED = BASE_EXT | A_BIT | C_BIT | F_BIT | D_BIT;
  localparam logic [25:0] WRITABLE  = SUPPORTED & MUTABLE_MASK;
  localparam logic [1:0]  MXL       = (XLEN == 32) ? 2'b01 : 2'b10;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] APPLY = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [25:0] cur_ext;
  logic [25:0] pend_ext;
  logic [25:0] cand_ext;
  logic [25:0] legal_ext;
  logic        accept;
  logic        differs;

  // Only the extension field of the write data and PC bit 1 matter
  wire unused_bits = ^{csr_wdata_i[XLEN-1:26], next_pc_i[XLEN-1:2], next_pc_i[0]};

  assign accept  = csr_we_i && (state == IDLE);
  assign differs = (legal_ext != cur_ext);

  // Merge writable bits from the write data, then apply the legality rules
  always_comb begin
    cand_ext  = (csr_wdata_i[25:0] & WRITABLE) | (cur_ext & ~WRITABLE);
    legal_ext = cand_ext;
    // D cannot be enabled without F
    if (legal_ext[EXT_D] && !legal_ext[EXT_F]) begin
      legal_ext[EXT_D] = 1'b0;
    end
    // Dropping C while the next instruction is only 2-byte aligned would
    // leave the PC misaligned, so C keeps its current value instead
    if (cur_ext[EXT_C] && !legal_ext[EXT_C] && next_pc_i[1]) begin
      legal_ext[EXT_C] = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a real change walks IDLE -> FLUSH -> APPLY -> IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && differs) state_next = FLUSH;
      FLUSH:   if (flush_ack_i)       state_next = APPLY;
      APPLY:                          state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // Outputs decoded purely from state
  always_comb begin
    csr_ready_o = (state == IDLE);
    flush_req_o = (state == FLUSH);
    change_o    = (state == APPLY);
  end

  // Pending value captured on acceptance, committed to current in APPLY
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_ext  <= SUPPORTED;
      pend_ext <= SUPPORTED;
    end else begin
      if (accept && differs) begin
        pend_ext <= legal_ext;
      end
      if (state == APPLY) begin
        cur_ext <= pend_ext;
      end
    end
  end

  assign misa_o   = {MXL, {(XLEN-28){1'b0}}, cur_ext};
  assign ext_en_o = cur_ext;

endmodule
`default_nettype wire
